// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one word access per request, served after LATENCY wait cycles.
// Optional alignment checking is compiled in with `define DMEM_ALIGN_CHK_EN.
module dmem_responder #(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_ren,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        mem_stall,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        done,
   output logic        misaligned,
   output logic [1:0]  dbg_state
);

   // Handshake: a request is held by the MEM stage while mem_stall is high; it is
   // sampled only in IDLE, and the stage advances on the edge that ends the DONE cycle.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              wen_q;
   logic              mis_q;
   logic [31:0]       rdata_q;
   logic              rvalid_q;
   logic              done_q;
   logic [31:0]       mem_q [2**ADDR_W];

   logic req_present;
   logic req_mis;
   logic access_fire;
   logic mem_write;
   logic unused_addr_bits;

   assign req_present = req_valid & (req_ren | req_wen);

`ifdef DMEM_ALIGN_CHK_EN
   assign req_mis = (req_addr[1:0] != 2'b00);
`else
   assign req_mis = 1'b0;
`endif

   assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

   assign access_fire = (state_q == S_BUSY) && (cnt_q == 4'd0);
   // A misaligned write is dropped; reset wins over a write on the same edge.
   assign mem_write   = access_fire & wen_q & ~mis_q & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         addr_q   <= '0;
         wdata_q  <= 32'd0;
         wen_q    <= 1'b0;
         mis_q    <= 1'b0;
         rdata_q  <= 32'd0;
         rvalid_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         rvalid_q <= 1'b0;
         done_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_present) begin
                  addr_q  <= req_addr[ADDR_W+1:2];
                  wdata_q <= req_wdata;
                  wen_q   <= req_wen;
                  mis_q   <= req_mis;
                  cnt_q   <= CNT_INIT;
                  state_q <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  done_q <= 1'b1;
                  if (!wen_q) begin
                     rdata_q  <= mis_q ? 32'd0 : mem_q[addr_q];
                     rvalid_q <= 1'b1;
                  end
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (mem_write) begin
         mem_q[addr_q] <= wdata_q;
      end
   end

   assign mem_stall   = (state_q == S_BUSY) | ((state_q == S_IDLE) & req_present);
   assign rdata       = rdata_q;
   assign rdata_valid = rvalid_q;
   assign done        = done_q;
   assign misaligned  = mis_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table of accesses, hand-written corner sequences, read-data scoreboard.
// Build with +define+DMEM_ALIGN_CHK_EN to check the alignment variant.
module tb_dmem_responder;

  localparam int ADDR_W  = 8;
  localparam int LATENCY = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ren;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        done;
  logic        misaligned;
  logic [1:0]  dbg_state;

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ren    (req_ren),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_stall  (mem_stall),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .done       (done),
    .misaligned (misaligned),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_mem [256];
  logic [31:0] last_rdata = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard: every rdata_valid pulse must match the oldest expected read
  always @(negedge clk) begin
    if (!rst && rdata_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdata_unexpected: got rdata_valid=1 expected 0 (rdata %h)", rdata);
      end else begin
        check("rdata", rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // driver: one complete access, with per-cycle stall/done checks
  task automatic do_access(input logic ren, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit change_addr,
                           input logic exp_rv, input logic [31:0] exp_rd, input logic exp_mis);
    if (exp_rv) exp_q.push_back(exp_rd);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_ren   = ren;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    for (int k = 0; k <= LATENCY; k++) begin
      @(negedge clk);
      check("stall_busy", {31'd0, mem_stall}, 32'd1);
      check("done_busy", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
      if (change_addr && k == 0) begin
        req_addr  = addr + 32'd4;
        req_wdata = ~wdata;
      end
    end
    @(negedge clk);
    check("stall_done", {31'd0, mem_stall}, 32'd0);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("rdata_valid", {31'd0, rdata_valid}, {31'd0, exp_rv});
    check("misaligned", {31'd0, misaligned}, {31'd0, exp_mis});
    if (!exp_rv) check("rdata_hold", rdata, last_rdata);
    else last_rdata = exp_rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_ren   = 1'b0;
    req_wen   = 1'b0;
    @(negedge clk);
    check("stall_idle", {31'd0, mem_stall}, 32'd0);
    check("done_idle", {31'd0, done}, 32'd0);
  endtask

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_rv;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[13];
  int   rnd_idx[8];

  initial begin
    logic [31:0] a;
    logic [31:0] d;

    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h0000_1234, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h0000_1234};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h2020_2020, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0024, 32'h2424_2424, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 1'b1, 32'h0000_0028, 32'h2828_2828, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0028, 32'h0,         1'b1, 32'h2828_2828};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'hFFFF_0000, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 32'hFFFF_07FC, 32'h0,         1'b1, 32'hFFFF_0000};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_0030, 32'h3030_3030, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0050, 32'h5050_5050, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_0040, 32'h4040_4040, 1'b0, 32'h0};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_ren   = 1'b0;
    req_wen   = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rvalid", {31'd0, rdata_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_mis", {31'd0, misaligned}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      do_access(vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].wdata, 1'b0,
                vecs[i].exp_rv, vecs[i].exp_rd, 1'b0);
    end

    // address changes after acceptance are ignored
    do_access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b1, 1'b1, 32'h2020_2020, 1'b0);

    // bubbles: write enable without req_valid never starts an access
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wen   = 1'b1;
    req_addr  = 32'h0000_0050;
    req_wdata = 32'h0000_0BAD;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bubble_stall", {31'd0, mem_stall}, 32'd0);
      check("bubble_done", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
    end
    req_wen = 1'b0;
    do_access(1'b1, 1'b0, 32'h0000_0050, 32'h0, 1'b0, 1'b1, 32'h5050_5050, 1'b0);

    // reset in the first BUSY cycle cancels the write
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 32'h0000_0030;
    req_wdata = 32'h0000_AAAA;
    @(negedge clk);
    check("rstmid_stall_accept", {31'd0, mem_stall}, 32'd1);
    @(posedge clk); #1;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_stall", {31'd0, mem_stall}, 32'd0);
    check("rstmid_done", {31'd0, done}, 32'd0);
    check("rstmid_rvalid", {31'd0, rdata_valid}, 32'd0);
    check("rstmid_rdata", rdata, 32'd0);
    check("rstmid_state", {30'd0, dbg_state}, 32'd0);
    last_rdata = 32'd0;
    do_access(1'b1, 1'b0, 32'h0000_0030, 32'h0, 1'b0, 1'b1, 32'h3030_3030, 1'b0);

    // misaligned accesses to the word at 0x40
`ifdef DMEM_ALIGN_CHK_EN
    do_access(1'b0, 1'b1, 32'h0000_0042, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 1'b1);
    do_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 1'b1, 32'h4040_4040, 1'b0);
    do_access(1'b1, 1'b0, 32'h0000_0043, 32'h0, 1'b0, 1'b1, 32'h0000_0000, 1'b1);
    do_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 1'b1, 32'h4040_4040, 1'b0);
`else
    do_access(1'b0, 1'b1, 32'h0000_0042, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 1'b0);
    do_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
    do_access(1'b1, 1'b0, 32'h0000_0043, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
`endif

    // random writes into words 64..127, then read back against the model
    for (int i = 0; i < 8; i++) begin
      rnd_idx[i] = $urandom_range(127, 64);
      a = 32'(rnd_idx[i]) << 2;
      d = $urandom;
      model_mem[rnd_idx[i]] = d;
      do_access(1'b0, 1'b1, a, d, 1'b0, 1'b0, 32'h0, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      a = 32'(rnd_idx[i]) << 2;
      do_access(1'b1, 1'b0, a, 32'h0, 1'b0, 1'b1, model_mem[rnd_idx[i]], 1'b0);
    end

    repeat (2) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
